// File: rtl/gf571_mul_seq.sv
// GF(2^571) multiplier sequencer: time-multiplexes one 286x286 carry-less
// multiplier over three Karatsuba sub-products, recombines the 1141-bit raw
// product and reduces it modulo f(x) = x^571 + x^10 + x^5 + x^2 + 1.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair valid          in_ready  block can accept operands
//   a, b       571-bit operands (bit i = coefficient of x^i)
//   out_valid  result valid                out_ready consumer accepts result
//   c          A*B mod f(x), held until the next result overwrites it
//   busy       high whenever the controller is not idle

// 286x286 carry-less multiplier, purely combinational.
module mult286 (
    input  logic [285:0] x,
    input  logic [285:0] y,
    output logic [571:0] d
);
    always_comb begin
        d = '0;
        for (int i = 0; i < 286; i++) begin
            if (y[i]) d = d ^ (572'(x) << i);
        end
    end
endmodule

module gf571_mul_seq #(
    parameter int unsigned MULT_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [570:0] a,
    input  logic [570:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [570:0] c,
    output logic         busy
);
    localparam int unsigned N     = 571;
    localparam int unsigned HALF  = 286;
    localparam int unsigned ACC_W = 2 * N - 1;
    localparam int unsigned R_W   = 580;
    localparam int unsigned CNT_W = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, MUL0, MUL1, MUL2, FOLD1, FOLD2, DONE
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [N-1:0]       c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [HALF-1:0]    a_lo_c, a_hi_c, b_lo_c, b_hi_c;
    logic [HALF-1:0]    mx_c, my_c;
    logic [2*HALF-1:0]  prod_c, mul_d_c;
    logic [ACC_W-1:0]   p_ext_c;
    logic               last_c;
    logic [N-2:0]       h_c;
    logic [R_W-1:0]     fold1_c;
    logic [8:0]         h2_c;
    logic [N-1:0]       fold2_c;

    // Karatsuba halves; the high half is zero-extended to 286 bits.
    assign a_lo_c = a_q[HALF-1:0];
    assign b_lo_c = b_q[HALF-1:0];
    assign a_hi_c = {1'b0, a_q[N-1:HALF]};
    assign b_hi_c = {1'b0, b_q[N-1:HALF]};

    // Operand select for the shared multiplier.
    always_comb begin
        mx_c = '0;
        my_c = '0;
        case (state_q)
            MUL0: begin mx_c = a_lo_c;          my_c = b_lo_c;          end
            MUL1: begin mx_c = a_lo_c ^ a_hi_c; my_c = b_lo_c ^ b_hi_c; end
            MUL2: begin mx_c = a_hi_c;          my_c = b_hi_c;          end
            default: ;
        endcase
    end

    mult286 u_mult (
        .x (mx_c),
        .y (my_c),
        .d (prod_c)
    );

    // Optional multiplier latency, modelled as a delay line on the product.
    generate
        if (MULT_LAT == 0) begin : g_comb
            assign mul_d_c = prod_c;
        end else begin : g_pipe
            logic [2*HALF-1:0] pipe_q [MULT_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(MULT_LAT); i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= prod_c;
                    for (int i = 1; i < int'(MULT_LAT); i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_d_c = pipe_q[MULT_LAT-1];
        end
    endgenerate

    assign p_ext_c = ACC_W'(mul_d_c);
    assign last_c  = (cnt_q == CNT_W'(MULT_LAT));

    // First fold: x^571 == x^10 + x^5 + x^2 + 1, leaves at most 9 overflow bits.
    assign h_c     = acc_q[ACC_W-1:N];
    assign fold1_c = R_W'(acc_q[N-1:0]) ^ R_W'(h_c) ^ (R_W'(h_c) << 2)
                   ^ (R_W'(h_c) << 5) ^ (R_W'(h_c) << 10);

    // Second fold clears the remaining overflow completely.
    assign h2_c    = r_q[R_W-1:N];
    assign fold2_c = r_q[N-1:0] ^ N'(h2_c) ^ (N'(h2_c) << 2)
                   ^ (N'(h2_c) << 5) ^ (N'(h2_c) << 10);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL0;
                end
            end
            MUL0, MUL1, MUL2: begin
                if (last_c) begin
                    cnt_d = '0;
                    case (state_q)
                        MUL0: begin
                            acc_d   = acc_q ^ p_ext_c ^ (p_ext_c << HALF);
                            state_d = MUL1;
                        end
                        MUL1: begin
                            acc_d   = acc_q ^ (p_ext_c << HALF);
                            state_d = MUL2;
                        end
                        default: begin
                            acc_d   = acc_q ^ (p_ext_c << HALF) ^ (p_ext_c << (2 * HALF));
                            state_d = FOLD1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FOLD1: begin
                r_d     = fold1_c;
                state_d = FOLD2;
            end
            FOLD2: begin
                c_d     = fold2_c;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            r_q         <= r_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_gf571_mul_seq.sv
// Bench for gf571_mul_seq: two instances (MULT_LAT=0 and MULT_LAT=2) share
// stimulus; results are checked against a bit-serial reference model through
// per-instance expectation queues.
module tb_gf571_mul_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [570:0] a, b;
    logic         in_ready0, out_valid0, busy0;
    logic         in_ready1, out_valid1, busy1;
    logic [570:0] c0, c1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [570:0] q0[$];
    logic [570:0] q1[$];
    logic [570:0] e0, e1;

    always #5 clk = ~clk;

    gf571_mul_seq #(.MULT_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .c(c0), .busy(busy0)
    );

    gf571_mul_seq #(.MULT_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .c(c1), .busy(busy1)
    );

    typedef struct {
        logic [570:0] a;
        logic [570:0] b;
        logic [570:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [570:0] act, input logic [570:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Bit-serial Horner multiply with reduction after each shift.
    function automatic logic [570:0] gf_ref(input logic [570:0] x, input logic [570:0] y);
        logic [571:0] r;
        logic [571:0] poly;
        poly = (572'(1) << 571) | 572'h425;
        r = '0;
        for (int i = 570; i >= 0; i--) begin
            r = r << 1;
            if (r[571]) r = r ^ poly;
            if (y[i]) r = r ^ {1'b0, x};
        end
        return r[570:0];
    endfunction

    function automatic logic [570:0] rand571();
        logic [575:0] t;
        for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
        return t[570:0];
    endfunction

    // Output monitors: pop an expectation on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL c0_unexpected: got %h expected no output", c0);
            end else begin
                e0 = q0.pop_front();
                chk("c0", c0, e0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL c1_unexpected: got %h expected no output", c1);
            end else begin
                e1 = q1.pop_front();
                chk("c1", c1, e1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready0 && in_ready1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 571'(1), 571'(0));
    endtask

    task automatic accept(input logic [570:0] ta, input logic [570:0] tb_v);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [570:0] ta, input logic [570:0] tb_v, input logic [570:0] exp);
        int n;
        wait_idle();
        q0.push_back(exp);
        q1.push_back(exp);
        accept(ta, tb_v);
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            chk("result_timeout", 571'(1), 571'(0));
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[6];
        logic [570:0] one, xa, xb, ra, rb, ev;
        int           lat0, lat1, n;

        one = 571'd1;
        vecs[0] = '{a: one << 570, b: one << 1,   exp: 571'h425};
        vecs[1] = '{a: one << 285, b: one << 286, exp: 571'h425};
        vecs[2] = '{a: one << 570, b: one << 570, exp: gf_ref(one << 570, one << 570)};
        vecs[3] = '{a: '1,         b: one,        exp: '1};
        vecs[4] = '{a: 571'd3,     b: 571'd3,     exp: 571'd5};
        vecs[5] = '{a: one << 300, b: one << 270, exp: one << 570};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready0", 571'(in_ready0), 571'(1));
        chk("rst_out_valid0", 571'(out_valid0), 571'(0));
        chk("rst_busy0", 571'(busy0), 571'(0));
        chk("rst_c0", c0, '0);
        chk("rst_in_ready1", 571'(in_ready1), 571'(1));
        chk("rst_c1", c1, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1*1: latency and return to idle.
        q0.push_back(one);
        q1.push_back(one);
        accept(one, one);
        lat0 = -1;
        lat1 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid0 && lat0 < 0) lat0 = i;
            if (out_valid1 && lat1 < 0) lat1 = i;
            if (lat0 >= 0 && i == lat0 + 1) chk("in_ready0_after", 571'(in_ready0), 571'(1));
            if (lat1 >= 0 && i == lat1 + 1) chk("in_ready1_after", 571'(in_ready1), 571'(1));
        end
        chk("latency0", 571'(lat0), 571'(6));
        chk("latency1", 571'(lat1), 571'(12));
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure in DONE: output held, new operands refused.
        xa = rand571();
        xb = rand571();
        ev = gf_ref(xa, xb);
        wait_idle();
        q0.push_back(ev);
        q1.push_back(ev);
        out_ready = 1'b0;
        accept(xa, xb);
        n = 0;
        while (!(out_valid0 && out_valid1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("bp_timeout", 571'(1), 571'(0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid0", 571'(out_valid0), 571'(1));
            chk("bp_c0", c0, ev);
            chk("bp_in_ready0", 571'(in_ready0), 571'(0));
            chk("bp_out_valid1", 571'(out_valid1), 571'(1));
            chk("bp_c1", c1, ev);
            @(posedge clk); #1;
            a = rand571();
            in_valid = (k % 2 == 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_done_valid0", 571'(out_valid0), 571'(0));
        chk("bp_done_busy0", 571'(busy0), 571'(0));
        chk("bp_done_ready0", 571'(in_ready0), 571'(1));
        chk("bp_done_valid1", 571'(out_valid1), 571'(0));
        chk("bp_done_busy1", 571'(busy1), 571'(0));
        chk("bp_c0_after", c0, ev);
        chk("bp_queue", 571'(q0.size() + q1.size()), 571'(0));
        @(posedge clk); #1;

        // Reset during MUL1 abandons the operation.
        wait_idle();
        accept(rand571(), rand571());
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        a = rand571();
        b = rand571();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready0", 571'(in_ready0), 571'(1));
        chk("mid_rst_out_valid0", 571'(out_valid0), 571'(0));
        chk("mid_rst_busy0", 571'(busy0), 571'(0));
        chk("mid_rst_c0", c0, '0);
        chk("mid_rst_busy1", 571'(busy1), 571'(0));
        chk("mid_rst_c1", c1, '0);
        @(posedge clk); #1;
        run_txn(571'd3, 571'd3, 571'd5);

        // Random pairs, some with an all-ones or all-zero upper half.
        for (int i = 0; i < 1000; i++) begin
            ra = rand571();
            rb = rand571();
            if (i % 4 == 1) ra[570:286] = '1;
            if (i % 4 == 2) rb[570:286] = '0;
            run_txn(ra, rb, gf_ref(ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
